// File: rtl/vga_draw_arbiter_pkg.sv
// mv_draw_pkg: shared VGA drawing widths, screen geometry and arbiter state encoding.
package mv_draw_pkg;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOR_W  = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_e;
endpackage

// File: rtl/vga_draw_arbiter_if.sv
// vga_draw_arbiter_if: requester bundle on one side, VGA adapter pixel port on the other.
interface vga_draw_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]                     req;
    logic [NUM_REQ-1:0]                     plot_in;
    logic [NUM_REQ*mv_draw_pkg::X_W-1:0]     x_in;
    logic [NUM_REQ*mv_draw_pkg::Y_W-1:0]     y_in;
    logic [NUM_REQ*mv_draw_pkg::COLOR_W-1:0] color_in;
    logic [NUM_REQ-1:0]                     grant;
    logic                                   busy;
    logic                                   timeout_err;
    logic                                   plot;
    logic [mv_draw_pkg::X_W-1:0]             X;
    logic [mv_draw_pkg::Y_W-1:0]             Y;
    logic [mv_draw_pkg::COLOR_W-1:0]         color;
    modport master (
        output req, plot_in, x_in, y_in, color_in,
        input  grant, busy, timeout_err, plot, X, Y, color
    );
    modport slave (
        input  req, plot_in, x_in, y_in, color_in,
        output grant, busy, timeout_err, plot, X, Y, color
    );
endinterface

// File: rtl/vga_draw_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first eligible index after the pointer.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);
    logic [PW-1:0] k;
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int i = 1; i <= N; i++) begin
            k = PW'((int'(ptr_i) + i) % N);
            if (!valid_o && eligible_i[k]) begin
                valid_o    = 1'b1;
                idx_o      = k;
                grant_o[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin ownership of the VGA pixel port with a hold watchdog.
module vga_draw_arbiter
    import mv_draw_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 131072
) (
    input logic               clock,
    input logic               resetn,
    vga_draw_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q, lock_q, pick_grant;
    logic [PW-1:0]      owner_q, ptr_q, pick_idx;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, tout_q, plot_q, pick_valid, expire, own_req, own_plot;
    logic [X_W-1:0]     x_q, own_x;
    logic [Y_W-1:0]     y_q, own_y;
    logic [COLOR_W-1:0] color_q, own_color;

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .eligible_i (bus.req & ~lock_q),
        .ptr_i      (ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    always_comb begin
        own_req   = 1'b0;
        own_plot  = 1'b0;
        own_x     = '0;
        own_y     = '0;
        own_color = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == PW'(k)) begin
                own_req   = bus.req[k];
                own_plot  = bus.plot_in[k];
                own_x     = bus.x_in[k*X_W +: X_W];
                own_y     = bus.y_in[k*Y_W +: Y_W];
                own_color = bus.color_in[k*COLOR_W +: COLOR_W];
            end
        end
        cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
        expire = (MAX_HOLD != 0) && (cnt_d == CW'(MAX_HOLD));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            lock_q  <= '0;
            owner_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            tout_q <= 1'b0;
            lock_q <= lock_q & bus.req;
            case (state_q)
                IDLE: if (pick_valid) begin
                    grant_q <= pick_grant;
                    owner_q <= pick_idx;
                    busy_q  <= 1'b1;
                    state_q <= OWN;
                end
                OWN: begin
                    cnt_q   <= cnt_d;
                    x_q     <= own_x;
                    y_q     <= own_y;
                    color_q <= own_color;
                    // a requester dropping req on the expiry cycle is a clean release
                    if (!own_req || expire) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        ptr_q   <= owner_q;
                        state_q <= GAP;
                        if (own_req) begin
                            tout_q          <= 1'b1;
                            lock_q[owner_q] <= 1'b1;
                        end
                    end else begin
                        plot_q <= own_plot;
                    end
                end
                GAP: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tout_q;
    assign bus.plot        = plot_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.color       = color_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed and random stimulus against an owner/queue-level arbiter model.
module tb_vga_draw_arbiter;
    localparam int N  = 3;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vga_draw_arbiter_if #(.NUM_REQ(N)) bus();
    vga_draw_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [N-1:0] req = '0;
    logic [N-1:0] pin = '0;
    logic [8:0]   xs[N];
    logic [7:0]   ys[N];
    logic [2:0]   cs[N];
    assign bus.req      = req;
    assign bus.plot_in  = pin;
    assign bus.x_in     = {xs[2], xs[1], xs[0]};
    assign bus.y_in     = {ys[2], ys[1], ys[0]};
    assign bus.color_in = {cs[2], cs[1], cs[0]};

    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the port, how long it has held, whether we are in the dead cycle.
    int         m_owner = -1;
    int         m_hold  = 0;
    int         m_ptr   = N - 1;
    int         k;
    bit         m_gap   = 1'b0;
    bit         m_lock[N];
    logic [N-1:0] e_grant = '0;
    bit         e_busy, e_tout, e_plot;
    logic [8:0] e_x = '0;
    logic [7:0] e_y = '0;
    logic [2:0] e_c = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_owner = -1; m_hold = 0; m_ptr = N - 1; m_gap = 1'b0;
            foreach (m_lock[i]) m_lock[i] = 1'b0;
            e_busy = 0; e_tout = 0; e_plot = 0; e_x = '0; e_y = '0; e_c = '0;
        end else begin
            e_tout = 0;
            for (int i = 0; i < N; i++) if (!req[i]) m_lock[i] = 1'b0;
            if (m_owner >= 0) begin
                m_hold++;
                e_x = xs[m_owner]; e_y = ys[m_owner]; e_c = cs[m_owner];
                if (!req[m_owner] || m_hold == MH) begin
                    if (req[m_owner]) begin
                        e_tout = 1;
                        m_lock[m_owner] = 1'b1;
                    end
                    e_plot = 0; m_ptr = m_owner; m_owner = -1; m_gap = 1'b1;
                end else begin
                    e_plot = pin[m_owner];
                end
            end else if (m_gap) begin
                m_gap = 1'b0; m_hold = 0;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_ptr + i) % N;
                    if (m_owner < 0 && req[k] && !m_lock[k]) m_owner = k;
                end
            end
            e_busy = (m_owner >= 0);
        end
        e_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    end

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("grant", bus.grant, e_grant);
            chk("busy", bus.busy, e_busy);
            chk("timeout_err", bus.timeout_err, e_tout);
            chk("plot", bus.plot, e_plot);
            if (e_plot) begin
                chk("X", bus.X, e_x);
                chk("Y", bus.Y, e_y);
                chk("color", bus.color, e_c);
            end
        end
    end

    task automatic wait_any(output logic [N-1:0] g);
        for (int i = 0; i < 40 && bus.grant == '0; i++) @(negedge clk);
        g = bus.grant;
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    logic [N-1:0] g;
    int n, pulses, job[N];
    logic tseen;
    initial begin
        foreach (xs[i]) begin xs[i] = '0; ys[i] = '0; cs[i] = '0; end
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_X", bus.X, 0);
        chk("rst_tout", bus.timeout_err, 0);
        resetn = 1'b1;

        // single requester, one-cycle pixel latency
        req = 3'b001; pin = 3'b001; xs[0] = 9'd5; ys[0] = 8'd7; cs[0] = 3'b100;
        @(negedge clk);
        chk("t1_grant", bus.grant, 3'b001);
        chk("t1_model_grant", e_grant, 3'b001);
        @(negedge clk);
        chk("t1_plot", bus.plot, 1);
        chk("t1_X", bus.X, 5);
        chk("t1_Y", bus.Y, 7);
        chk("t1_color", bus.color, 3'b100);
        chk("t1_model_x", e_x, 5);
        req = '0; pin = '0;
        repeat (3) @(negedge clk);

        // three-way tie after reset: order 0,1,2 with a dead cycle after each release
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1; req = 3'b111; pin = 3'b111;
        xs[0] = 9'd10; xs[1] = 9'd11; xs[2] = 9'd12;
        for (int j = 0; j < N; j++) begin
            wait_any(g);
            chk("rr_order", g, 3'b001 << j);
            @(negedge clk);
            req[j] = 1'b0;
            @(negedge clk);
            chk("gap_grant", bus.grant, 0);
            chk("gap_plot", bus.plot, 0);
        end
        pin = '0;
        repeat (3) @(negedge clk);

        // non-owner strobes never reach the adapter
        req = 3'b010; pin = 3'b110; xs[1] = 9'd20; xs[2] = 9'd300;
        wait_any(g);
        repeat (5) begin
            @(negedge clk);
            chk("no_x300", bus.X == 9'd300, 0);
            chk("owner_x", bus.X, 20);
        end
        req = '0; pin = '0;
        repeat (3) @(negedge clk);

        // watchdog: stuck requester revoked after MH cycles and locked out until it drops
        req = 3'b100;
        wait_any(g);
        n = 0;
        while (bus.grant[2] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("wd_hold", n, MH);
        chk("wd_tout", bus.timeout_err, 1);
        chk("wd_model_tout", e_tout, 1);
        pulses = 1;
        repeat (10) begin
            @(negedge clk);
            chk("wd_lock", bus.grant, 0);
            pulses += bus.timeout_err;
        end
        chk("wd_pulses", pulses, 1);
        req = '0;
        @(negedge clk);
        req = 3'b100;
        wait_any(g);
        chk("wd_regrant", g, 3'b100);
        req = '0;
        repeat (3) @(negedge clk);

        // release on the expiry cycle is not a timeout
        req = 3'b001;
        wait_any(g);
        repeat (MH - 1) @(negedge clk);
        req = '0;
        tseen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            tseen |= bus.timeout_err;
        end
        chk("edge_no_tout", tseen, 0);

        // reset during ownership
        req = 3'b010; pin = 3'b010; xs[1] = 9'd33; ys[1] = 8'd44; cs[1] = 3'd5;
        wait_any(g);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_plot", bus.plot, 0);
        chk("mid_rst_X", bus.X, 0);
        chk("mid_rst_Y", bus.Y, 0);
        chk("mid_rst_color", bus.color, 0);
        resetn = 1'b1; req = 3'b111;
        @(negedge clk);
        chk("rst_rr", bus.grant, 3'b001);
        req = '0; pin = '0;
        repeat (3) @(negedge clk);

        // random jobs, strobes, coordinates and occasional resets
        foreach (job[i]) job[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[i] = 1'b1;
                        job[i] = $urandom_range(1, 12);
                    end
                end else if (bus.grant[i]) begin
                    if (job[i] <= 1) req[i] = 1'b0;
                    else job[i]--;
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
                pin[i] = 1'($urandom);
                xs[i]  = 9'($urandom_range(0, 319));
                ys[i]  = 8'($urandom_range(0, 239));
                cs[i]  = 3'($urandom);
            end
        end
        resetn = 1'b1; req = '0; pin = '0;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
